// File: rtl/fd_scan_ctrl.sv
// fd_scan_ctrl
// ------------
// Scan controller for a FAST-style corner detector. It walks every reference
// pixel of the frame that has a full 3-pixel border in raster order. For each
// pixel it requests the centre and the 16 ring points from an external
// address calculator and SRAM, classifies each ring point against the centre,
// and flags the pixel as a corner when enough contiguous ring points are all
// bright or all dark.
//
// Ports
//   clk         in   1   single clock, rising edge
//   rst_n       in   1   synchronous active-low reset
//   start       in   1   begin a full-frame scan (sampled only in IDLE)
//   threshold   in   8   intensity threshold, latched on an accepted start
//   sramData    in   8   SRAM read data, valid one cycle after adjNumber != 0
//   refAddr     out  15  current reference pixel address (row*COLUMNS+col)
//   adjNumber   out  5   point selector: 0 none, 17 centre, 1..16 ring
//   cornerValid out  1   one-cycle pulse in EVAL when refAddr is a corner
//   cornerAddr  out  15  flagged address, valid with cornerValid
//   busy        out  1   high while a frame is being scanned
//   done        out  1   one-cycle pulse at end of frame
//
// Handshake: there is no back-pressure. A read is issued on every cycle where
// adjNumber != 0 and the SRAM must return the data on the following cycle.
//
// Per-pixel timeline (19 cycles, refAddr constant throughout):
//   ISSUE x17 (adjNumber 17,1..16) -> DRAIN (captures ring 16) -> EVAL.

module fd_scan_ctrl #(
    parameter int COLUMNS  = 180,
    parameter int ROWS     = 120,
    parameter int N_CONTIG = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  threshold,
    input  logic [7:0]  sramData,
    output logic [14:0] refAddr,
    output logic [4:0]  adjNumber,
    output logic        cornerValid,
    output logic [14:0] cornerAddr,
    output logic        busy,
    output logic        done
);

    localparam int FIRST_ROW = 3;
    localparam int LAST_ROW  = ROWS - 4;
    localparam int FIRST_COL = 3;
    localparam int LAST_COL  = COLUMNS - 4;

    localparam logic [14:0] FIRST_ADDR = 15'(FIRST_ROW * COLUMNS + FIRST_COL);
    // Jump from the last column of one row to the first column of the next.
    localparam logic [14:0] ROW_STEP   = 15'(COLUMNS - (LAST_COL - FIRST_COL));
    localparam logic [31:0] RUN_MASK   = (32'd1 << N_CONTIG) - 32'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_EVAL  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;          // ISSUE step 0..16 (0 = centre)
    logic [14:0] ref_q, ref_d;
    logic [14:0] row_q, row_d;
    logic [14:0] col_q, col_d;
    logic [7:0]  thr_q, thr_d;

    // Capture path: the selector issued last cycle tells where the data goes.
    logic [4:0]  adj_prev_q;
    logic [7:0]  c_q;
    logic [7:0]  p_q [16];              // p_q[k-1] holds ring point k

    logic [15:0] bright;
    logic [15:0] dark;
    logic        is_corner;
    logic        last_pixel;

    // True when v holds at least N_CONTIG consecutive ones, treating bit 15
    // as adjacent to bit 0. Doubling the vector unrolls the circle.
    function automatic logic has_run(input logic [15:0] v);
        logic [31:0] dbl;
        logic        found;
        dbl   = {v, v};
        found = 1'b0;
        for (int s = 0; s < 16; s++) begin
            if (((dbl >> s) & RUN_MASK) == RUN_MASK) found = 1'b1;
        end
        return found;
    endfunction

    // Classification in 9 bits so C+threshold and P+threshold cannot wrap.
    always_comb begin
        logic [8:0] c9;
        logic [8:0] t9;
        logic [8:0] p9;
        c9     = {1'b0, c_q};
        t9     = {1'b0, thr_q};
        bright = '0;
        dark   = '0;
        for (int k = 0; k < 16; k++) begin
            p9        = {1'b0, p_q[k]};
            bright[k] = p9 > (c9 + t9);
            dark[k]   = (p9 + t9) < c9;
        end
    end

    // Bright and dark runs are tested separately so they never merge.
    assign is_corner  = has_run(bright) || has_run(dark);
    assign last_pixel = (row_q == 15'(LAST_ROW)) && (col_q == 15'(LAST_COL));

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ref_d   = ref_q;
        row_d   = row_q;
        col_d   = col_q;
        thr_d   = thr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    idx_d   = 5'd0;
                    ref_d   = FIRST_ADDR;
                    row_d   = 15'(FIRST_ROW);
                    col_d   = 15'(FIRST_COL);
                    thr_d   = threshold;
                end
            end
            S_ISSUE: begin
                if (idx_q == 5'd16) begin
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_DRAIN: begin
                state_d = S_EVAL;
            end
            S_EVAL: begin
                if (last_pixel) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_ISSUE;
                    idx_d   = 5'd0;
                    if (col_q == 15'(LAST_COL)) begin
                        col_d = 15'(FIRST_COL);
                        row_d = row_q + 15'd1;
                        ref_d = ref_q + ROW_STEP;
                    end else begin
                        col_d = col_q + 15'd1;
                        ref_d = ref_q + 15'd1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        adjNumber   = 5'd0;
        cornerValid = 1'b0;
        cornerAddr  = 15'd0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_ISSUE: begin
                adjNumber = (idx_q == 5'd0) ? 5'd17 : idx_q;
                busy      = 1'b1;
            end
            S_DRAIN: begin
                busy = 1'b1;
            end
            S_EVAL: begin
                busy        = 1'b1;
                cornerValid = is_corner;
                cornerAddr  = ref_q;
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign refAddr = ref_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 5'd0;
            ref_q   <= 15'd0;
            row_q   <= 15'd0;
            col_q   <= 15'd0;
            thr_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ref_q   <= ref_d;
            row_q   <= row_d;
            col_q   <= col_d;
            thr_q   <= thr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            adj_prev_q <= 5'd0;
            c_q        <= 8'd0;
            for (int k = 0; k < 16; k++) p_q[k] <= 8'd0;
        end else begin
            adj_prev_q <= adjNumber;
            if (adj_prev_q == 5'd17) begin
                c_q <= sramData;
            end
            for (int k = 0; k < 16; k++) begin
                if (adj_prev_q == 5'(k + 1)) p_q[k] <= sramData;
            end
        end
    end

endmodule

// File: tb/tb_fd_scan_ctrl.sv
// tb_fd_scan_ctrl
// ---------------
// Self-checking bench for fd_scan_ctrl. The frame height is reduced to 8 rows
// (rows 3..4, 348 pixels) so full frames stay short; the width stays 180 so
// the first reference address is still 543. A behavioural SRAM returns pixel
// values chosen per reference address and ring point, one cycle after each
// read request.

module tb_fd_scan_ctrl;

    localparam int COLS   = 180;
    localparam int ROWS   = 8;
    localparam int PER_ROW = COLS - 6;              // columns 3..176
    localparam int NPIX   = (ROWS - 6) * PER_ROW;   // 348
    localparam int PER    = 19;
    localparam int FRAME  = NPIX * PER;             // 6612

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  threshold = 8'd0;
    logic [7:0]  sram_data = 8'd0;
    logic [14:0] ref_addr;
    logic [4:0]  adj_number;
    logic        corner_valid;
    logic [14:0] corner_addr;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    // Observations collected by run_frame.
    logic [14:0] got_q[$];
    logic [14:0] exp_q[$];
    int          adj_err, ref_err, busy_err, phase_err;
    int          done_cnt, done_cyc;
    logic [14:0] first_ref;
    logic        first_busy;
    logic [4:0]  first_adj;

    fd_scan_ctrl #(
        .COLUMNS (COLS),
        .ROWS    (ROWS),
        .N_CONTIG(9)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .threshold  (threshold),
        .sramData   (sram_data),
        .refAddr    (ref_addr),
        .adjNumber  (adj_number),
        .cornerValid(corner_valid),
        .cornerAddr (corner_addr),
        .busy       (busy),
        .done       (done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- image model ----------------
    // k = 17 is the centre, 1..16 the ring points.
    function automatic logic [7:0] pix(input int md, input int addr, input int k);
        if (md == 1) begin
            case (addr)
                543: return (k == 17) ? 8'd50 : ((k <= 9) ? 8'd200 : 8'd50);
                544: return (k == 17) ? 8'd100 : ((k >= 13 || k <= 5) ? 8'd200 : 8'd100);
                545: return (k == 17) ? 8'd100 : ((k >= 13 || k <= 4) ? 8'd200 : 8'd100);
                546: return (k == 17) ? 8'd100 : ((k % 2 == 1) ? 8'd200 : 8'd0);
                547: return (k <= 9) ? 8'd120 : 8'd100;
                548: return (k <= 9) ? 8'd121 : 8'd100;
                549: return (k <= 9) ? 8'd80 : 8'd100;
                550: return (k <= 9) ? 8'd79 : 8'd100;
                551: return (k == 17) ? 8'd100 : ((k <= 5) ? 8'd200 : ((k <= 9) ? 8'd0 : 8'd100));
                723: return (k == 17) ? 8'd100 : 8'd0;
                896: return (k == 17) ? 8'd100 : ((k >= 10 || k <= 2) ? 8'd200 : 8'd100);
                default: return 8'd100;
            endcase
        end else if (md == 2) begin
            case (addr)
                543: return (k == 17) ? 8'd250 : 8'd255;
                544: return (k <= 9) ? 8'd111 : 8'd100;
                545: return (k <= 9) ? 8'd110 : 8'd100;
                default: return 8'd100;
            endcase
        end
        return 8'd100;
    endfunction

    // Registered SRAM: data for this cycle's request appears next cycle.
    always @(posedge clk) begin
        sram_data <= pix(mode, int'(ref_addr), int'(adj_number));
    end

    // ---------------- driver / monitor ----------------
    // Starts a frame and samples every cycle until the frame plus a short idle
    // tail has passed. Optionally pulses start with threshold 0 mid-frame.
    task automatic run_frame(input int md, input logic [7:0] thr, input bit poke);
        int p, ph, exp_adj, exp_ref;
        mode = md;
        got_q.delete();
        adj_err = 0; ref_err = 0; busy_err = 0; phase_err = 0;
        done_cnt = 0; done_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        threshold = thr;
        @(negedge clk);
        start = 1'b0;
        first_ref  = ref_addr;
        first_busy = busy;
        first_adj  = adj_number;
        for (int c = 0; c < FRAME + 40; c++) begin
            if (c > 0) @(negedge clk);
            p  = c / PER;
            ph = c % PER;
            if (c < FRAME) begin
                exp_adj = (ph == 0) ? 17 : ((ph <= 16) ? ph : 0);
                exp_ref = (3 + p / PER_ROW) * COLS + 3 + (p % PER_ROW);
                if (adj_number !== 5'(exp_adj)) adj_err++;
                if (ref_addr !== 15'(exp_ref)) ref_err++;
                if (busy !== 1'b1) busy_err++;
            end else begin
                if (adj_number !== 5'd0) adj_err++;
                if (busy !== 1'b0) busy_err++;
            end
            if (corner_valid === 1'b1) begin
                got_q.push_back(corner_addr);
                if (ph != 18 || c >= FRAME) phase_err++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (poke && c == 5) begin
                start = 1'b1;
                threshold = 8'd0;
            end
            if (poke && c == 6) start = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (adj_number !== 5'd0) begin errors++; $display("FAIL reset_adj got %0d exp 0", adj_number); end
        checks++; if (ref_addr !== 15'd0) begin errors++; $display("FAIL reset_ref got %0d exp 0", ref_addr); end
        checks++; if (corner_valid !== 1'b0) begin errors++; $display("FAIL reset_cv got %b exp 0", corner_valid); end
        checks++; if (corner_addr !== 15'd0) begin errors++; $display("FAIL reset_ca got %0d exp 0", corner_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        rst_n = 1'b1;
    endtask

    task automatic test_uniform;
        run_frame(0, 8'd20, 1'b0);
        checks++; if (first_ref !== 15'd543) begin errors++; $display("FAIL uni_first_ref got %0d exp 543", first_ref); end
        checks++; if (first_busy !== 1'b1) begin errors++; $display("FAIL uni_first_busy got %b exp 1", first_busy); end
        checks++; if (first_adj !== 5'd17) begin errors++; $display("FAIL uni_first_adj got %0d exp 17", first_adj); end
        checks++; if (adj_err !== 0) begin errors++; $display("FAIL uni_adj_seq got %0d bad cycles exp 0", adj_err); end
        checks++; if (ref_err !== 0) begin errors++; $display("FAIL uni_ref_seq got %0d bad cycles exp 0", ref_err); end
        checks++; if (busy_err !== 0) begin errors++; $display("FAIL uni_busy got %0d bad cycles exp 0", busy_err); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL uni_corners got %0d exp 0", got_q.size()); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL uni_done_cnt got %0d exp 1", done_cnt); end
        checks++; if (done_cyc !== FRAME) begin errors++; $display("FAIL uni_done_cyc got %0d exp %0d", done_cyc, FRAME); end
    endtask

    // Compares the corner addresses seen in the last frame against exp_q.
    task automatic test_corner_patterns;
        run_frame(1, 8'd20, 1'b0);
        exp_q = '{15'd543, 15'd544, 15'd548, 15'd550, 15'd723, 15'd896};
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL pat_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size()) begin
                errors++; $display("FAIL pat_addr[%0d] got none exp %0d", i, exp_q[i]);
            end else if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL pat_addr[%0d] got %0d exp %0d", i, got_q[i], exp_q[i]);
            end
        end
        checks++; if (phase_err !== 0) begin errors++; $display("FAIL pat_cv_phase got %0d exp 0", phase_err); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL pat_done_cnt got %0d exp 1", done_cnt); end
    endtask

    task automatic test_start_ignored;
        run_frame(1, 8'd20, 1'b1);
        exp_q = '{15'd543, 15'd544, 15'd548, 15'd550, 15'd723, 15'd896};
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL ign_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size()) begin
                errors++; $display("FAIL ign_addr[%0d] got none exp %0d", i, exp_q[i]);
            end else if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL ign_addr[%0d] got %0d exp %0d", i, got_q[i], exp_q[i]);
            end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ign_done_cnt got %0d exp 1", done_cnt); end
        checks++; if (ref_err !== 0) begin errors++; $display("FAIL ign_ref_seq got %0d bad cycles exp 0", ref_err); end
    endtask

    task automatic test_midframe_reset;
        int seen_done, seen_busy;
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        threshold = 8'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++; if (adj_number !== 5'd0) begin errors++; $display("FAIL mrst_adj got %0d exp 0", adj_number); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b exp 0", busy); end
        checks++; if (corner_valid !== 1'b0) begin errors++; $display("FAIL mrst_cv got %b exp 0", corner_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mrst_done got %b exp 0", done); end
        checks++; if (ref_addr !== 15'd0) begin errors++; $display("FAIL mrst_ref got %0d exp 0", ref_addr); end
        seen_done = 0;
        seen_busy = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
            if (busy === 1'b1) seen_busy++;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL mrst_no_done got %0d exp 0", seen_done); end
        checks++; if (seen_busy !== 0) begin errors++; $display("FAIL mrst_idle got %0d busy cycles exp 0", seen_busy); end
    endtask

    // Also the restart after the mid-frame reset.
    task automatic test_overflow;
        run_frame(2, 8'd10, 1'b0);
        exp_q = '{15'd544};
        checks++; if (first_ref !== 15'd543) begin errors++; $display("FAIL ovf_restart_ref got %0d exp 543", first_ref); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        checks++;
        if (got_q.size() < 1) begin
            errors++; $display("FAIL ovf_addr got none exp %0d", exp_q[0]);
        end else if (got_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL ovf_addr got %0d exp %0d", got_q[0], exp_q[0]);
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ovf_done_cnt got %0d exp 1", done_cnt); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_uniform();
        test_corner_patterns();
        test_start_ignored();
        test_midframe_reset();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fd_scan_ctrl.md
FD_SCAN_CTRL -- requirements
Module: fd_scan_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- COLUMNS, 180, image width in pixels.
- ROWS, 120, image height in pixels.
- N_CONTIG, 9, minimum contiguous ring run that marks a corner.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin full-frame scan; sampled only in IDLE.
- threshold  in  8  intensity threshold; latched on accepted start.
- sramData  in  8  SRAM read data, valid one cycle after a nonzero adjNumber.
- refAddr  out  15  current reference pixel address, row*COLUMNS+col.
- adjNumber  out  5  point selector to the address calculator (0 idle, 17 centre, 1..16 ring).
- cornerValid  out  1  one-cycle pulse: current refAddr is a corner.
- cornerAddr  out  15  address of the flagged pixel, valid with cornerValid.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of frame.

Function
REQ-003 The scan SHALL visit rows 3..ROWS-4 and columns 3..COLUMNS-5+1 (3..176 at default) in raster order: first refAddr 543, last 21056, 19836 pixels.
REQ-004 States SHALL be IDLE, ISSUE, DRAIN, EVAL and FIN.
REQ-005 IDLE -> ISSUE when start=1; threshold SHALL be latched, busy SHALL rise, and refAddr SHALL be 543.
REQ-006 ISSUE SHALL drive adjNumber 17, 1, 2, ..., 16 on 17 consecutive cycles; the pixel SHALL then advance to DRAIN.
REQ-007 DRAIN SHALL last one cycle with adjNumber=0 while the ring-16 data is captured, then advance to EVAL.
REQ-008 The sramData captured one cycle after adjNumber=17 SHALL be stored as the centre value C.
REQ-009 The sramData captured one cycle after adjNumber=k SHALL be stored as ring value P[k].
REQ-010 Per-pixel period SHALL be exactly 19 cycles: 17 ISSUE, 1 DRAIN, 1 EVAL.
REQ-011 Point k SHALL be bright iff P[k] > C+threshold, using 9-bit unsigned arithmetic with no wrap.
REQ-012 Point k SHALL be dark iff P[k]+threshold < C, using 9-bit unsigned arithmetic with no wrap.
REQ-013 Equality at either bound SHALL classify the point as neither bright nor dark.
REQ-014 A corner SHALL require at least N_CONTIG contiguous bright points, or at least N_CONTIG contiguous dark points.
REQ-015 Ring order SHALL be circular: point 16 is adjacent to point 1.
REQ-016 Bright and dark points SHALL never combine into one run.
REQ-017 In EVAL, cornerValid SHALL equal the corner decision, and cornerAddr SHALL equal refAddr.
REQ-018 After a non-last pixel, EVAL SHALL return to ISSUE with the column incremented; at column 176 the column SHALL wrap to 3 and the row SHALL increment.
REQ-019 EVAL of refAddr 21056 SHALL go to FIN.
REQ-020 FIN SHALL pulse done for one cycle, drop busy, and return to IDLE.
REQ-021 start asserted outside IDLE SHALL be ignored, and threshold SHALL NOT change mid-frame.
REQ-022 adjNumber SHALL be 0 in IDLE, DRAIN, EVAL and FIN, so no SRAM read occurs in those states.
REQ-023 refAddr SHALL be held constant for all 19 cycles of a pixel.

Reset
REQ-024 With rst_n=0 at a clock edge, the block SHALL enter IDLE on that edge.
REQ-025 Reset values SHALL be: adjNumber=0, refAddr=0, cornerValid=0, cornerAddr=0, busy=0, done=0, C=0, P[*]=0, threshold latch=0.
REQ-026 Reset mid-frame SHALL abort the scan with no done pulse; a new start SHALL restart at refAddr 543.

Verification
REQ-027 Reset: hold rst_n=0 for 2 cycles mid-scan -> next cycle adjNumber=0, busy=0, cornerValid=0, done=0; no done pulse ever follows.
REQ-028 Uniform frame of all 100, threshold=20, start -> adjNumber sequence per pixel is 17,1..16,0,0; zero cornerValid pulses; done pulses once, 19836*19 cycles after the first ISSUE cycle.
REQ-029 Centre at 543 = 50, threshold=20, ring P1..P9 = 200, other ring points 50 -> cornerValid with cornerAddr=543 in that pixel's EVAL cycle.
REQ-030 Wrap-around: bright points 13..16 and 1..5 (9 run) -> corner. Bright points 13..16 and 1..4 (8 run) -> no corner. Alternating bright/dark on all 16 points -> no corner.
REQ-031 Threshold bounds, with C=100 and threshold=20:
- P = 120 -> not bright.
- P = 121 -> bright.
- P = 80 -> not dark.
- P = 79 -> dark.
- C=250, threshold=10 -> P=255 never bright (no overflow).
REQ-032 start pulsed while busy, with threshold changed to 0 -> ignored; results match the original threshold; exactly one done pulse.
